// File: rtl/t5_imem.sv
// t5_imem: 2^AW x 32 instruction memory with a byte-stream image loader
// and a single-cycle-latency Wishbone-style fetch port. The fetch port is
// only serviced once a complete image has been loaded (state DONE).
module t5_imem #(
  parameter int unsigned AW  = 10,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic          sclk,
  input  logic          srst,
  // fetch port
  input  logic [31:2]   iwb_adr,
  input  logic          iwb_stb,
  input  logic          iwb_wre,
  input  logic [3:0]    iwb_sel,
  output logic [31:0]   iwb_dat,
  output logic          iwb_ack,
  output logic          iwb_err,
  // image loader
  input  logic          ld_go,
  input  logic [AW:0]   ld_len,
  input  logic [7:0]    ld_dat,
  input  logic          ld_vld,
  output logic          ld_rdy,
  output logic          ld_done
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [AW:0]     len_q,      len_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [23:0]     asm_q,      asm_d;
  logic            ack_q,      ack_d;
  logic            err_q,      err_d;
  logic [31:0]     rd_data_q;

  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic            last_word;
  logic            req_in_range;
  logic [AW-1:0]   rd_addr;

  logic [31:0]     mem [DEPTH];

  // Byte selects have no effect: the port only ever returns full words.
  logic            unused_sel;
  assign unused_sel = ^iwb_sel;

  // The word being completed is the final one of the image.
  assign last_word = ({1'b0, word_cnt_q} == (len_q - (AW+1)'(1)));

  // Requests above the memory depth are answered with an error.
  assign req_in_range = (iwb_adr[31:AW+2] == '0);
  assign rd_addr      = iwb_adr[AW+1:2];

  // Loader next-state: go handling, byte assembly and word write strobe.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
    mem_wdata  = {ld_dat, asm_q};

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ld_go) begin
          len_d      = ld_len;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          state_d    = (ld_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // ld_go is deliberately ignored while an image is streaming in.
        if (ld_vld) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: asm_d[7:0]   = ld_dat;
            2'd1: asm_d[15:8]  = ld_dat;
            2'd2: asm_d[23:16] = ld_dat;
            2'd3: begin
              mem_we = 1'b1;
              if (last_word) begin
                state_d = ST_DONE;
              end else begin
                word_cnt_d = word_cnt_q + AW'(1);
              end
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch response: only a request seen while DONE gets an ack.
  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    if ((state_q == ST_DONE) && iwb_stb) begin
      ack_d = 1'b1;
      err_d = iwb_wre || !req_in_range;
    end
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Memory array: loader write port and registered fetch read port.
  // NOTE: the array and its read register are deliberately left out of
  // reset so the image survives srst and the array maps onto block RAM;
  // iwb_dat is masked to NOP whenever no good response is pending.
  always_ff @(posedge sclk) begin
    if (mem_we) begin
      mem[word_cnt_q] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign iwb_ack = ack_q;
  assign iwb_err = err_q;
  assign iwb_dat = (ack_q && !err_q) ? rd_data_q : NOP;
  assign ld_rdy  = (state_q == ST_LOAD);
  assign ld_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_t5_imem.sv
// Bench for t5_imem: directed load/fetch sequences, a behavioural model
// checked on every falling edge, and literal spot checks.
module tb_t5_imem;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          sclk = 1'b0;
  logic          srst = 1'b0;
  logic [31:2]   iwb_adr = '0;
  logic          iwb_stb = 1'b0;
  logic          iwb_wre = 1'b0;
  logic [3:0]    iwb_sel = 4'hF;
  logic [31:0]   iwb_dat;
  logic          iwb_ack;
  logic          iwb_err;
  logic          ld_go = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic [7:0]    ld_dat = '0;
  logic          ld_vld = 1'b0;
  logic          ld_rdy;
  logic          ld_done;

  int n_checks = 0;
  int n_pass   = 0;

  t5_imem #(.AW(AW), .NOP(NOP)) dut (
    .sclk    (sclk),
    .srst    (srst),
    .iwb_adr (iwb_adr),
    .iwb_stb (iwb_stb),
    .iwb_wre (iwb_wre),
    .iwb_sel (iwb_sel),
    .iwb_dat (iwb_dat),
    .iwb_ack (iwb_ack),
    .iwb_err (iwb_err),
    .ld_go   (ld_go),
    .ld_len  (ld_len),
    .ld_dat  (ld_dat),
    .ld_vld  (ld_vld),
    .ld_rdy  (ld_rdy),
    .ld_done (ld_done)
  );

  initial forever #5 sclk = ~sclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for go, 1 = receiving bytes, 2 = image ready
  int          m_phase  = 0;
  int          m_len    = 0;
  int          m_nbytes = 0;
  logic [7:0]  m_lane [4];
  logic [31:0] m_mem [DEPTH];
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_dat = NOP;

  always @(posedge sclk or negedge srst) begin
    if (!srst) begin
      m_phase  = 0;
      m_nbytes = 0;
      m_ack    = 1'b0;
      m_err    = 1'b0;
      m_dat    = NOP;
    end else begin
      if (iwb_stb && m_phase == 2) begin
        m_ack = 1'b1;
        if (iwb_wre || ((iwb_adr >> AW) != 0)) begin
          m_err = 1'b1;
          m_dat = NOP;
        end else begin
          m_err = 1'b0;
          m_dat = m_mem[int'(iwb_adr) % DEPTH];
        end
      end else begin
        m_ack = 1'b0;
        m_err = 1'b0;
        m_dat = NOP;
      end

      if (m_phase == 1) begin
        if (ld_vld) begin
          m_lane[m_nbytes % 4] = ld_dat;
          m_nbytes++;
          if (m_nbytes % 4 == 0)
            m_mem[m_nbytes / 4 - 1] = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
          if (m_nbytes == m_len * 4) m_phase = 2;
        end
      end else if (ld_go) begin
        if (ld_len == 0) begin
          m_phase = 2;
        end else begin
          m_phase  = 1;
          m_len    = int'(ld_len);
          m_nbytes = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge sclk) begin
    check("cycle", {28'd0, iwb_ack, iwb_err, ld_rdy, ld_done, iwb_dat},
          {28'd0, m_ack, m_err, (m_phase == 1), (m_phase == 2), m_dat});
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_dat = b;
    ld_vld = 1'b1;
    step();
    ld_vld = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_ack",  {63'd0, iwb_ack}, 64'd0);
    check("rst_dat",  {32'd0, iwb_dat}, {32'd0, NOP});
    check("rst_rdy",  {63'd0, ld_rdy},  64'd0);
    check("rst_done", {63'd0, ld_done}, 64'd0);
    step(); step();
    srst = 1'b1;
    step();

    // fetch while IDLE is dropped
    iwb_stb = 1'b1; iwb_adr = '0;
    step();
    check("idle_fetch_ack", {63'd0, iwb_ack}, 64'd0);
    check("idle_fetch_dat", {32'd0, iwb_dat}, {32'd0, NOP});
    iwb_stb = 1'b0;

    // two-word load, vld gaps on word 0, fetch and go noise during LOAD
    ld_len = 11'd2; ld_go = 1'b1;
    step();
    ld_go = 1'b0;
    check("load_rdy", {63'd0, ld_rdy}, 64'd1);
    iwb_stb = 1'b1; iwb_adr = '0;
    send_byte(8'h78); step();
    send_byte(8'h56); step();
    send_byte(8'h34); step();
    send_byte(8'h12);
    ld_go = 1'b1; ld_len = 11'd5;
    step();
    ld_go = 1'b0; ld_len = 11'd2;
    check("load_fetch_dropped", {63'd0, iwb_ack}, 64'd0);
    check("load_fetch_nop", {32'd0, iwb_dat}, {32'd0, NOP});
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    iwb_stb = 1'b0;
    check("done_after_8", {62'd0, ld_done, ld_rdy}, 64'd2);

    // back-to-back fetch 0,1,0
    iwb_stb = 1'b1; iwb_adr = 30'd0;
    step();
    iwb_adr = 30'd1;
    check("fetch0", {31'd0, iwb_ack, iwb_dat}, {31'd0, 1'b1, 32'h1234_5678});
    step();
    iwb_adr = 30'd0;
    check("fetch1", {31'd0, iwb_ack, iwb_dat}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    step();
    iwb_stb = 1'b0;
    check("fetch2", {31'd0, iwb_ack, iwb_dat}, {31'd0, 1'b1, 32'h1234_5678});
    step();
    check("fetch_idle", {31'd0, iwb_ack, iwb_dat}, {31'd0, 1'b0, NOP});

    // error responses: out of range, write attempt, high address bit
    iwb_stb = 1'b1; iwb_adr = 30'd1024;
    step();
    iwb_adr = 30'd0; iwb_wre = 1'b1;
    check("err_range", {30'd0, iwb_ack, iwb_err, iwb_dat}, {30'd0, 2'b11, NOP});
    step();
    iwb_wre = 1'b0;
    check("err_write", {30'd0, iwb_ack, iwb_err, iwb_dat}, {30'd0, 2'b11, NOP});
    step();
    iwb_adr = 30'h2000_0001;
    check("read_after_wre", {30'd0, iwb_ack, iwb_err, iwb_dat}, {30'd0, 2'b10, 32'h1234_5678});
    step();
    iwb_stb = 1'b0;
    check("err_high_bit", {62'd0, iwb_ack, iwb_err}, 64'd3);
    step();

    // request on the DONE->LOAD edge is answered, then dropped in LOAD
    iwb_stb = 1'b1; iwb_adr = 30'd1; ld_go = 1'b1; ld_len = 11'd2;
    step();
    ld_go = 1'b0;
    check("reload_edge_ack", {31'd0, iwb_ack, iwb_dat}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    check("reload_rdy", {63'd0, ld_rdy}, 64'd1);
    step();
    check("reload_drop", {63'd0, iwb_ack}, 64'd0);
    iwb_stb = 1'b0;

    // reset mid-load after five bytes
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    srst = 1'b0;
    #1;
    check("async_rst", {61'd0, ld_rdy, ld_done, iwb_ack}, 64'd0);
    step();
    srst = 1'b1;
    step();

    // zero-length go jumps straight to DONE; memory kept new word 0
    ld_len = '0; ld_go = 1'b1;
    step();
    ld_go = 1'b0;
    check("len0_done", {62'd0, ld_done, ld_rdy}, 64'd2);
    iwb_stb = 1'b1; iwb_adr = 30'd0;
    step();
    iwb_adr = 30'd1;
    check("kept_word0", {32'd0, iwb_dat}, {32'd0, 32'h4433_2211});
    step();
    iwb_stb = 1'b0;
    check("kept_word1", {32'd0, iwb_dat}, {32'd0, 32'hDEAD_BEEF});
    step();

    // new load restarts at word 0, byte 0
    ld_len = 11'd1; ld_go = 1'b1;
    step();
    ld_go = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    check("restart_done", {63'd0, ld_done}, 64'd1);
    iwb_stb = 1'b1; iwb_adr = 30'd0;
    step();
    iwb_stb = 1'b0;
    check("restart_word0", {32'd0, iwb_dat}, {32'd0, 32'hDDCC_BBAA});
    step();

    // full-depth load: exactly 2^AW words, no wrap
    ld_len = 11'd1024; ld_go = 1'b1;
    step();
    ld_go = 1'b0;
    for (int i = 0; i < 4096; i++) send_byte(8'((i * 7 + 3) & 255));
    check("full_done", {63'd0, ld_done}, 64'd1);
    iwb_stb = 1'b1; iwb_adr = 30'd0;
    step();
    iwb_adr = 30'd1023;
    check("full_first", {32'd0, iwb_dat}, {32'd0, 32'h1811_0A03});
    step();
    iwb_adr = 30'd1024;
    check("full_last", {32'd0, iwb_dat}, {32'd0, 32'hFCF5_EEE7});
    step();
    iwb_stb = 1'b0;
    check("full_beyond", {62'd0, iwb_ack, iwb_err}, 64'd3);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t5_imem.md
T5_IMEM -- requirements
Module: t5_imem

Interface
REQ-001 Parameter AW, default 10, word-address width; memory depth 2^AW x 32 bits (4 KiB at default).
REQ-002 Parameter NOP, default 32'h00000013, word returned on bus when no valid instruction is available.
REQ-003 sclk  input  1  single clock; all state changes on posedge sclk.
REQ-004 srst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 iwb_adr  input  [31:2]  fetch word address.
REQ-006 iwb_stb  input  1  fetch strobe; a request is presented every cycle it is 1.
REQ-007 iwb_wre  input  1  write enable; 1 = illegal write on the instruction port.
REQ-008 iwb_sel  input  [3:0]  byte selects; ignored (full-word reads only).
REQ-009 iwb_dat  output  [31:0]  instruction word.
REQ-010 iwb_ack  output  1  response valid for the request of the previous cycle.
REQ-011 iwb_err  output  1  response error for the request of the previous cycle.
REQ-012 ld_go  input  1  single-cycle pulse; starts an image load.
REQ-013 ld_len  input  [AW:0]  number of words to load; sampled on accepted ld_go.
REQ-014 ld_dat  input  [7:0]  load byte stream, little-endian within each word.
REQ-015 ld_vld  input  1  ld_dat valid.
REQ-016 ld_rdy  output  1  loader accepts a byte; transfer occurs when ld_vld & ld_rdy.
REQ-017 ld_done  output  1  image loaded; fetch port is serviced.

Function
REQ-018 Loader FSM states: IDLE, LOAD, DONE; reset state IDLE.
REQ-019 IDLE: ld_go with ld_len != 0 -> LOAD; ld_go with ld_len == 0 -> DONE; otherwise remain.
REQ-020 LOAD: ld_rdy = 1; byte counter (0..3) and word counter (0..ld_len-1) start at 0 on entry.
REQ-021 LOAD: each transfer places ld_dat into byte lane [byte counter]; on the 4th byte the assembled word is written to mem[word counter] in that cycle, byte counter wraps to 0, word counter increments.
REQ-022 LOAD: 4th byte of word ld_len-1 -> DONE in the next cycle; ld_len = 2^AW fills the memory exactly, with no wrap.
REQ-023 ld_go in LOAD is ignored; ld_vld = 0 holds all counters.
REQ-024 DONE: ld_done = 1 and ld_rdy = 0; ld_go with ld_len != 0 -> LOAD (reload), with ld_len == 0 stays DONE.
REQ-025 ld_rdy = 0 and ld_done = 0 in IDLE; ld_rdy = 0 and ld_done = 0 in LOAD except as stated in REQ-020.
REQ-026 Fetch is serviced only in DONE; latency is 1 cycle: a request sampled at edge N produces iwb_ack/iwb_err/iwb_dat valid during the cycle after edge N, held until edge N+1.
REQ-027 DONE, iwb_stb = 1, iwb_wre = 0, iwb_adr[31:AW+2] == 0: iwb_dat = mem[iwb_adr[AW+1:2]], iwb_ack = 1, iwb_err = 0.
REQ-028 DONE, iwb_stb = 1 with out-of-range address or iwb_wre = 1: iwb_dat = NOP, iwb_ack = 1, iwb_err = 1; memory is not modified.
REQ-029 iwb_stb = 0, or state != DONE at the sampling edge: next cycle iwb_ack = 0, iwb_err = 0, iwb_dat = NOP.
REQ-030 Back-to-back requests every cycle sustain one response per cycle with no bubbles.
REQ-031 A request sampled in the same edge as the DONE->LOAD transition is still answered (state DONE at sampling); requests during LOAD are dropped with no ack.

Reset
REQ-032 Asserting srst forces, immediately and independently of sclk: state IDLE, counters 0, ld_rdy = 0, ld_done = 0, iwb_ack = 0, iwb_err = 0, iwb_dat = NOP.
REQ-033 Memory contents are not reset; words written before a mid-load reset persist and the partial word is discarded.
REQ-034 Deassertion of srst takes effect at the first posedge sclk at which srst is sampled high.

Verification
REQ-035 ld_len = 2, ld_go, bytes 78 56 34 12 EF BE AD DE -> mem[0] = 32'h12345678, mem[1] = 32'hDEADBEEF, ld_done = 1 on the cycle after the 8th byte.
REQ-036 After REQ-035, fetch adr 0, 1, 0 on consecutive cycles -> iwb_dat = 12345678, DEADBEEF, 12345678 with iwb_ack = 1 on three consecutive cycles, each one cycle after its request.
REQ-037 Fetch adr = 2^AW (AW = 10, word 1024), or iwb_wre = 1 at adr 0 -> iwb_dat = 00000013, iwb_ack = 1, iwb_err = 1; a subsequent read of mem[0] returns 12345678.
REQ-038 Fetch with stb = 1 in IDLE and during LOAD -> iwb_ack = 0, iwb_dat = 00000013; ld_vld toggled 1/0 during LOAD -> bytes accepted only on vld cycles.
REQ-039 srst low after 5 bytes of a 2-word load -> ld_rdy = 0, ld_done = 0, iwb_ack = 0 asynchronously; mem[0] keeps its new value; a new ld_go restarts at word 0, byte 0.
REQ-040 ld_go with ld_len = 0 from IDLE -> DONE next cycle, ld_rdy never 1; ld_go pulsed again mid-LOAD -> no restart, word count unchanged.
